// File: rtl/sd_command_engine.sv
// SPI-mode SD command engine: sends one CRC7-protected command frame,
// collects an R1 or R3/R7 response, retries on response timeout and can
// stream one or more data blocks into the cache as DATA_W-bit words.
module sd_command_engine #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int BLOCK_BYTES = 512,
    parameter int BCNT_W      = 8,
    parameter int NCR_MAX     = 16,
    parameter int TOKEN_MAX   = 4096,
    parameter int MAX_RETRY   = 2
) (
    input  logic              clk400,
    input  logic              reset,
    input  logic              SDin,
    output logic              SDout,
    input  logic [5:0]        command,
    input  logic [31:0]       argument,
    input  logic              resp_long,
    input  logic              data_read,
    input  logic [BCNT_W-1:0] block_count,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [7:0]        response,
    output logic [31:0]       response_ext,
    output logic [2:0]        status,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_data,
    output logic              cache_we
);

    localparam int BLOCK_BITS = BLOCK_BYTES * 8;
    localparam int M1         = (NCR_MAX > 48) ? NCR_MAX : 48;
    localparam int M2         = (TOKEN_MAX > M1) ? TOKEN_MAX : M1;
    localparam int CNT_MAX    = (BLOCK_BITS > M2) ? BLOCK_BITS : M2;
    localparam int CW         = $clog2(CNT_MAX + 1);
    localparam int RW         = $clog2(MAX_RETRY + 2);
    localparam int WB         = $clog2(DATA_W);

    localparam logic [2:0] ST_OK     = 3'd0;
    localparam logic [2:0] ST_RTO    = 3'd1;
    localparam logic [2:0] ST_R1ERR  = 3'd2;
    localparam logic [2:0] ST_TOKTO  = 3'd3;
    localparam logic [2:0] ST_DATERR = 3'd4;

    typedef enum logic [2:0] {
        IDLE, SEND, WAIT_RESP, RESP, WAIT_TOKEN, DATA, CRC, DONE
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic [RW-1:0]     retry;
    logic [WB-1:0]     wcnt;
    logic [47:0]       frame;
    logic              resp_l;
    logic              rd_data;
    logic [BCNT_W-1:0] blk_rem;
    logic [38:0]       resp_sr;
    logic [7:0]        win;
    logic [DATA_W-2:0] word_sr;

    // Next-state decode outputs
    logic              st_we;
    logic [2:0]        st_n;
    logic              rsp_last;
    logic              retry_inc;
    logic [39:0]       rfull;
    logic [7:0]        r1_n;
    logic [7:0]        tok_win;
    logic [DATA_W-1:0] word_n;
    logic              word_last;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign SDout     = (state == SEND) ? frame[6'd47 - cnt[5:0]] : 1'b1;
    assign rfull     = {resp_sr, SDin};
    assign r1_n      = resp_l ? rfull[39:32] : rfull[7:0];
    assign tok_win   = {win[6:0], SDin};
    assign word_n    = {word_sr, SDin};
    assign word_last = (state == DATA) && (wcnt == WB'(DATA_W - 1));

    // State register
    always_ff @(posedge clk400 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and status decode
    always_comb begin
        state_n   = state;
        st_we     = 1'b0;
        st_n      = ST_OK;
        rsp_last  = 1'b0;
        retry_inc = 1'b0;
        case (state)
            IDLE: if (start) state_n = SEND;
            SEND: if (cnt == CW'(47)) state_n = WAIT_RESP;
            WAIT_RESP: begin
                if (!SDin) begin
                    state_n = RESP;
                end else if (cnt == CW'(NCR_MAX - 1)) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_inc = 1'b1;
                        state_n   = SEND;
                    end else begin
                        st_we   = 1'b1;
                        st_n    = ST_RTO;
                        state_n = DONE;
                    end
                end
            end
            RESP: begin
                if (cnt == (resp_l ? CW'(38) : CW'(6))) begin
                    rsp_last = 1'b1;
                    if (r1_n != 8'h00) begin
                        st_we   = 1'b1;
                        st_n    = ST_R1ERR;
                        state_n = DONE;
                    end else if (rd_data) begin
                        state_n = WAIT_TOKEN;
                    end else begin
                        st_we   = 1'b1;
                        st_n    = ST_OK;
                        state_n = DONE;
                    end
                end
            end
            WAIT_TOKEN: begin
                if (tok_win == 8'hFE) begin
                    state_n = DATA;
                end else if (tok_win[7:5] == 3'b000 && cnt >= CW'(7)) begin
                    st_we   = 1'b1;
                    st_n    = ST_DATERR;
                    state_n = DONE;
                end else if (cnt == CW'(TOKEN_MAX - 1)) begin
                    st_we   = 1'b1;
                    st_n    = ST_TOKTO;
                    state_n = DONE;
                end
            end
            DATA: if (cnt == CW'(BLOCK_BITS - 1)) state_n = CRC;
            CRC: begin
                if (cnt == CW'(15)) begin
                    if (blk_rem > BCNT_W'(1)) begin
                        state_n = WAIT_TOKEN;
                    end else begin
                        st_we   = 1'b1;
                        st_n    = ST_OK;
                        state_n = DONE;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Phase counter restarts on every state change; also tracks retries
    always_ff @(posedge clk400 or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            retry <= '0;
        end else begin
            if (state == IDLE || state_n != state) cnt <= '0;
            else                                   cnt <= cnt + 1'b1;
            if (state == IDLE && start) retry <= '0;
            else if (retry_inc)         retry <= retry + 1'b1;
        end
    end

    // Latch the transaction request and build the command frame
    always_ff @(posedge clk400 or negedge reset) begin
        if (!reset) begin
            frame   <= '0;
            resp_l  <= 1'b0;
            rd_data <= 1'b0;
            blk_rem <= '0;
        end else if (state == IDLE && start) begin
            frame   <= {2'b01, command, argument,
                        crc7({2'b01, command, argument}), 1'b1};
            resp_l  <= resp_long;
            rd_data <= data_read;
            blk_rem <= (block_count == '0) ? BCNT_W'(1) : block_count;
        end else if (state == CRC && cnt == CW'(15)) begin
            blk_rem <= blk_rem - 1'b1;
        end
    end

    // Response shift register and result/status registers
    always_ff @(posedge clk400 or negedge reset) begin
        if (!reset) begin
            resp_sr      <= '0;
            response     <= '0;
            response_ext <= '0;
            status       <= '0;
        end else begin
            if (state == WAIT_RESP) resp_sr <= '0;
            else if (state == RESP) resp_sr <= rfull[38:0];
            if (state == IDLE && start) begin
                response     <= '0;
                response_ext <= '0;
                status       <= ST_OK;
            end
            if (rsp_last) begin
                response     <= r1_n;
                response_ext <= resp_l ? rfull[31:0] : 32'h0;
            end
            if (st_we) status <= st_n;
        end
    end

    // Start-token window, cleared each time WAIT_TOKEN is entered
    always_ff @(posedge clk400 or negedge reset) begin
        if (!reset)                   win <= '0;
        else if (state == WAIT_TOKEN) win <= tok_win;
        else                          win <= '0;
    end

    // Data packing and cache write port
    always_ff @(posedge clk400 or negedge reset) begin
        if (!reset) begin
            wcnt       <= '0;
            word_sr    <= '0;
            cache_we   <= 1'b0;
            cache_data <= '0;
            cache_addr <= '0;
        end else begin
            if (state == DATA) begin
                wcnt    <= wcnt + 1'b1;
                word_sr <= word_n[DATA_W-2:0];
            end else begin
                wcnt    <= '0;
            end
            cache_we <= word_last;
            if (word_last) cache_data <= word_n;
            if (state == IDLE && start) cache_addr <= '0;
            else if (cache_we)          cache_addr <= cache_addr + 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_command_engine.sv
// Directed bench for sd_command_engine with a reactive card model that
// captures each command frame and replays a scripted SDin bit stream.
`timescale 1ns/1ps
module tb_sd_command_engine;

    logic        clk400 = 1'b0;
    logic        reset;
    logic        SDin = 1'b1;
    logic        SDout;
    logic [5:0]  command;
    logic [31:0] argument;
    logic        resp_long;
    logic        data_read;
    logic [7:0]  block_count;
    logic        start;
    logic        busy;
    logic        done;
    logic [7:0]  response;
    logic [31:0] response_ext;
    logic [2:0]  status;
    logic [7:0]  cache_addr;
    logic [15:0] cache_data;
    logic        cache_we;

    int n_chk = 0;
    int n_err = 0;

    // card model state
    bit          tmpl[$];
    bit          play[$];
    logic [47:0] fr_cap;
    logic [47:0] last_frame;
    int          cap_n;
    bit          capturing;
    int          nframes;

    // monitor state
    int          done_cnt;
    int          wr_cnt;
    int          wr_bad;
    logic [15:0] first_data;
    logic [7:0]  first_addr;
    logic [7:0]  last_addr;

    sd_command_engine #(
        .DATA_W(16), .ADDR_W(8), .BLOCK_BYTES(512), .BCNT_W(8),
        .NCR_MAX(32), .TOKEN_MAX(4096), .MAX_RETRY(2)
    ) dut (
        .clk400(clk400), .reset(reset), .SDin(SDin), .SDout(SDout),
        .command(command), .argument(argument), .resp_long(resp_long),
        .data_read(data_read), .block_count(block_count), .start(start),
        .busy(busy), .done(done), .response(response),
        .response_ext(response_ext), .status(status),
        .cache_addr(cache_addr), .cache_data(cache_data), .cache_we(cache_we)
    );

    always #5 clk400 = ~clk400;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_ones(input int n);
        for (int i = 0; i < n; i++) tmpl.push_back(1'b1);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) tmpl.push_back(b[i]);
    endtask

    task automatic push_block();
        logic [7:0] b;
        for (int j = 0; j < 512; j++) begin
            b = 8'(j);
            push_byte(b);
        end
        push_byte(8'h12);
        push_byte(8'h34);
    endtask

    // Card: drive the next scripted bit, then watch SDout for a frame
    initial begin
        capturing = 0;
        nframes   = 0;
        forever begin
            @(negedge clk400);
            if (!reset) begin
                capturing = 0;
                play.delete();
                SDin = 1'b1;
            end else begin
                if (play.size() > 0) SDin = play.pop_front();
                else                 SDin = 1'b1;
                if (capturing) begin
                    fr_cap = {fr_cap[46:0], SDout};
                    cap_n++;
                    if (cap_n == 48) begin
                        capturing  = 0;
                        nframes++;
                        last_frame = fr_cap;
                        play       = tmpl;
                    end
                end else if (busy && SDout == 1'b0) begin
                    capturing = 1;
                    fr_cap    = 48'h0;
                    cap_n     = 1;
                end
            end
        end
    end

    // Monitor: done pulses and cache strobes against the ramp payload
    initial begin
        logic [7:0]  w;
        logic [15:0] exp_d;
        logic [7:0]  exp_a;
        forever begin
            @(negedge clk400);
            if (reset) begin
                if (done) done_cnt++;
                if (cache_we) begin
                    w     = 8'(wr_cnt % 256);
                    exp_d = {8'(2 * w), 8'(2 * w + 1)};
                    exp_a = 8'(wr_cnt % 256);
                    if (cache_data !== exp_d || cache_addr !== exp_a) wr_bad++;
                    if (wr_cnt == 0) begin
                        first_data = cache_data;
                        first_addr = cache_addr;
                    end
                    last_addr = cache_addr;
                    wr_cnt++;
                end
            end
        end
    end

    task automatic clear_counts();
        done_cnt = 0; wr_cnt = 0; wr_bad = 0; nframes = 0;
        first_data = '0; first_addr = '0; last_addr = '0;
    endtask

    task automatic issue(input logic [5:0] cmd, input logic [31:0] arg,
                         input logic rl, input logic dr, input logic [7:0] bc);
        clear_counts();
        @(negedge clk400);
        command = cmd; argument = arg; resp_long = rl; data_read = dr;
        block_count = bc; start = 1'b1;
        @(negedge clk400);
        start = 1'b0; command = 6'h3F; argument = 32'hFFFF_FFFF;
        resp_long = ~rl; data_read = ~dr;
    endtask

    task automatic run_cmd(input string tag, input logic [5:0] cmd, input logic [31:0] arg,
                           input logic rl, input logic dr, input logic [7:0] bc,
                           input int budget);
        bit got;
        issue(cmd, arg, rl, dr, bc);
        // a start while busy must be ignored
        repeat (3) @(negedge clk400);
        command = 6'd8; start = 1'b1;
        @(negedge clk400);
        start = 1'b0;
        got = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk400);
            if (done) begin got = 1; break; end
        end
        check({tag, "_done_seen"}, 64'(got), 64'd1);
        repeat (4) @(negedge clk400);
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    endtask

    initial begin
        bit got;
        reset = 1'b0; start = 1'b0; command = '0; argument = '0;
        resp_long = 1'b0; data_read = 1'b0; block_count = '0;
        clear_counts();
        repeat (3) @(negedge clk400);
        check("rst_sdout",  64'(SDout), 64'd1);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(done), 64'd0);
        check("rst_we",     64'(cache_we), 64'd0);
        check("rst_resp",   64'(response), 64'd0);
        check("rst_ext",    64'(response_ext), 64'd0);
        check("rst_status", 64'(status), 64'd0);
        check("rst_addr",   64'(cache_addr), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk400);

        // CMD0: R1 0x01 after three idle bytes
        tmpl.delete(); push_ones(24); push_byte(8'h01);
        run_cmd("cmd0", 6'd0, 32'h0, 1'b0, 1'b0, 8'd0, 400);
        check("cmd0_frame",  64'(last_frame), 64'h4000_0000_0095);
        check("cmd0_frames", 64'(nframes), 64'd1);
        check("cmd0_resp",   64'(response), 64'h01);
        check("cmd0_ext",    64'(response_ext), 64'h0);
        check("cmd0_status", 64'(status), 64'd2);
        check("cmd0_writes", 64'(wr_cnt), 64'd0);
        check("cmd0_busy",   64'(busy), 64'd0);

        // CMD8: long R7 response
        tmpl.delete(); push_ones(8);
        push_byte(8'h01); push_byte(8'h00); push_byte(8'h00);
        push_byte(8'h01); push_byte(8'hAA);
        run_cmd("cmd8", 6'd8, 32'h0000_01AA, 1'b1, 1'b0, 8'd0, 400);
        check("cmd8_frame",  64'(last_frame), 64'h4800_0001_AA87);
        check("cmd8_resp",   64'(response), 64'h01);
        check("cmd8_ext",    64'(response_ext), 64'h0000_01AA);
        check("cmd8_status", 64'(status), 64'd2);

        // CMD17: single block read
        tmpl.delete(); push_ones(8); push_byte(8'h00);
        push_ones(100); push_byte(8'hFE); push_block();
        run_cmd("cmd17", 6'd17, 32'h0, 1'b0, 1'b1, 8'd1, 6000);
        check("cmd17_resp",   64'(response), 64'h00);
        check("cmd17_status", 64'(status), 64'd0);
        check("cmd17_writes", 64'(wr_cnt), 64'd256);
        check("cmd17_bad",    64'(wr_bad), 64'd0);
        check("cmd17_first",  64'(first_data), 64'h0001);
        check("cmd17_faddr",  64'(first_addr), 64'd0);
        check("cmd17_laddr",  64'(last_addr), 64'd255);

        // CMD18: two blocks, address wraps into the second block
        tmpl.delete(); push_ones(8); push_byte(8'h00);
        push_ones(100); push_byte(8'hFE); push_block();
        push_ones(20);  push_byte(8'hFE); push_block();
        run_cmd("cmd18", 6'd18, 32'h0, 1'b0, 1'b1, 8'd2, 12000);
        check("cmd18_status", 64'(status), 64'd0);
        check("cmd18_writes", 64'(wr_cnt), 64'd512);
        check("cmd18_bad",    64'(wr_bad), 64'd0);
        check("cmd18_laddr",  64'(last_addr), 64'd255);

        // No response: two retries then RESP_TIMEOUT
        tmpl.delete();
        run_cmd("rto", 6'd0, 32'h0, 1'b0, 1'b0, 8'd0, 1000);
        check("rto_frames", 64'(nframes), 64'd3);
        check("rto_frame",  64'(last_frame), 64'h4000_0000_0095);
        check("rto_status", 64'(status), 64'd1);

        // Error token 0x08 right after a good R1
        tmpl.delete(); push_ones(4); push_byte(8'h00); push_byte(8'h08);
        run_cmd("derr", 6'd17, 32'h0, 1'b0, 1'b1, 8'd1, 400);
        check("derr_status", 64'(status), 64'd4);
        check("derr_writes", 64'(wr_cnt), 64'd0);

        // Good R1, no token ever
        tmpl.delete(); push_ones(4); push_byte(8'h00);
        run_cmd("tto", 6'd17, 32'h0, 1'b0, 1'b1, 8'd1, 6000);
        check("tto_status", 64'(status), 64'd3);

        // Reset during DATA aborts with no done
        tmpl.delete(); push_ones(8); push_byte(8'h00);
        push_ones(10); push_byte(8'hFE); push_block();
        issue(6'd17, 32'h0, 1'b0, 1'b1, 8'd1);
        got = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk400);
            if (wr_cnt >= 10) begin got = 1; break; end
        end
        check("abort_reached_data", 64'(got), 64'd1);
        reset = 1'b0;
        #1;
        check("abort_sdout",  64'(SDout), 64'd1);
        check("abort_busy",   64'(busy), 64'd0);
        check("abort_we",     64'(cache_we), 64'd0);
        check("abort_status", 64'(status), 64'd0);
        check("abort_addr",   64'(cache_addr), 64'd0);
        repeat (3) @(negedge clk400);
        check("abort_done_cnt", 64'(done_cnt), 64'd0);
        check("abort_bad",      64'(wr_bad), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk400);
        tmpl.delete(); push_ones(8); push_byte(8'h01);
        run_cmd("after", 6'd0, 32'h0, 1'b0, 1'b0, 8'd0, 400);
        check("after_frame",  64'(last_frame), 64'h4000_0000_0095);
        check("after_resp",   64'(response), 64'h01);
        check("after_status", 64'(status), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
